// File: rtl/ahb_response_mux.sv
// ============================================================================
// ahb_response_mux : AHB slave-to-master response mux with a default slave
//                    that answers unmapped transfers with a two-cycle ERROR.
// Revision 1.0
// ============================================================================
`default_nettype none

module ahb_response_mux #(
  parameter int                    NUM_SLAVES    = 4,
  parameter int                    NUM_MASTERS   = 2,
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_RDATA = 32'hDEADBEEF,
  parameter int                    ERRCNT_WIDTH  = 8,
  localparam int                   MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                              Hclk,
  input  logic                              Hresetn,
  input  logic [NUM_SLAVES-1:0]             Hsel,
  input  logic [1:0]                        Htrans,
  input  logic [MW-1:0]                     Hmaster,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]  Hrdata_S,
  input  logic [2*NUM_SLAVES-1:0]           Hresp_S,
  input  logic [NUM_SLAVES-1:0]             Hreadyout_S,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] Hrdata_M,
  output logic [2*NUM_MASTERS-1:0]          Hresp_M,
  output logic                              Hready,
  output logic [MW-1:0]                     Hmaster_data,
  output logic [ERRCNT_WIDTH-1:0]           err_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  logic [NUM_SLAVES-1:0]   sel_q;
  logic [MW-1:0]           mst_q;
  logic                    err_req_q;
  state_t                  state_q;
  logic [ERRCNT_WIDTH-1:0] err_count_q;

  logic                    unmapped_d;
  logic                    err_active;
  logic [DATA_WIDTH-1:0]   rdata_sel;
  logic [1:0]              resp_sel;
  logic                    ready_sel;

  // Only NONSEQ/SEQ to unmapped space is an error; IDLE/BUSY get a zero-wait OKAY.
  assign unmapped_d = (Hsel == '0) && Htrans[1];

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      sel_q       <= '0;
      mst_q       <= '0;
      err_req_q   <= 1'b0;
      state_q     <= ST_IDLE;
      err_count_q <= '0;
    end else begin
      if (Hready) begin
        sel_q     <= Hsel;
        mst_q     <= Hmaster;
        err_req_q <= unmapped_d;
      end
      case (state_q)
        ST_ERR1: state_q <= ST_ERR2;
        default: state_q <= (Hready && unmapped_d) ? ST_ERR1 : ST_IDLE;
      endcase
      if (Hready && unmapped_d && (err_count_q != '1)) begin
        err_count_q <= err_count_q + ERRCNT_WIDTH'(1);
      end
    end
  end

  assign err_active = (state_q != ST_IDLE) && err_req_q;

  always_comb begin
    rdata_sel = DEFAULT_RDATA;
    resp_sel  = RESP_OKAY;
    ready_sel = 1'b1;
    // Descending scan so the lowest set select bit wins on multi-hot input.
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (sel_q[i]) begin
        rdata_sel = Hrdata_S[i*DATA_WIDTH +: DATA_WIDTH];
        resp_sel  = Hresp_S[2*i +: 2];
        ready_sel = Hreadyout_S[i];
      end
    end
    if (err_active) begin
      rdata_sel = DEFAULT_RDATA;
      resp_sel  = RESP_ERROR;
      ready_sel = (state_q == ST_ERR2);
    end
  end

  always_comb begin
    Hrdata_M = {NUM_MASTERS{DEFAULT_RDATA}};
    Hresp_M  = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (mst_q == MW'(m)) begin
        Hrdata_M[m*DATA_WIDTH +: DATA_WIDTH] = rdata_sel;
        Hresp_M[2*m +: 2]                    = resp_sel;
      end
    end
  end

  assign Hready       = ready_sel;
  assign Hmaster_data = mst_q;
  assign err_count    = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_ahb_response_mux.sv
// ============================================================================
// tb_ahb_response_mux : directed self-checking bench for ahb_response_mux.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ahb_response_mux;

  localparam int NS = 4;
  localparam int NM = 2;
  localparam int DW = 32;
  localparam logic [DW-1:0] DEF = 32'hDEADBEEF;

  logic              Hclk;
  logic              Hresetn;
  logic [NS-1:0]     Hsel;
  logic [1:0]        Htrans;
  logic [0:0]        Hmaster;
  logic [NS*DW-1:0]  Hrdata_S;
  logic [2*NS-1:0]   Hresp_S;
  logic [NS-1:0]     Hreadyout_S;
  logic [NM*DW-1:0]  Hrdata_M;
  logic [2*NM-1:0]   Hresp_M;
  logic              Hready;
  logic [0:0]        Hmaster_data;
  logic [7:0]        err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  ahb_response_mux #(
    .NUM_SLAVES(NS), .NUM_MASTERS(NM), .DATA_WIDTH(DW),
    .DEFAULT_RDATA(DEF), .ERRCNT_WIDTH(8)
  ) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hsel(Hsel), .Htrans(Htrans),
    .Hmaster(Hmaster), .Hrdata_S(Hrdata_S), .Hresp_S(Hresp_S),
    .Hreadyout_S(Hreadyout_S), .Hrdata_M(Hrdata_M), .Hresp_M(Hresp_M),
    .Hready(Hready), .Hmaster_data(Hmaster_data), .err_count(err_count)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " Hready"},  64'(Hready),         64'd1);
    check({tag, " Hresp_M"}, 64'(Hresp_M),        64'd0);
    check({tag, " rdata0"},  64'(Hrdata_M[31:0]), 64'(DEF));
    check({tag, " rdata1"},  64'(Hrdata_M[63:32]),64'(DEF));
  endtask

  initial begin
    // Reset with arbitrary inputs
    Hresetn     = 1'b0;
    Hsel        = 4'b0010;
    Htrans      = 2'b10;
    Hmaster     = 1'b1;
    Hrdata_S    = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    Hresp_S     = 8'b01_01_01_01;
    Hreadyout_S = 4'b0000;
    #3;
    check_idle_outputs("reset");
    check("reset err_count", 64'(err_count), 64'd0);
    check("reset mst_data",  64'(Hmaster_data), 64'd0);
    @(negedge Hclk);
    Hresetn = 1'b1;

    // Wait-state read from slave 2 by master 1
    Hsel = 4'b0100; Htrans = 2'b10; Hmaster = 1'b1;
    Hreadyout_S = 4'b1111; Hresp_S = 8'b00;
    tick();
    Hsel = 4'b0000; Htrans = 2'b00; Hmaster = 1'b0;
    Hreadyout_S[2] = 1'b0;
    #1;
    check("wait Hready", 64'(Hready), 64'd0);
    check("wait mst_data", 64'(Hmaster_data), 64'd1);
    tick();
    check("wait held mst", 64'(Hmaster_data), 64'd1);
    Hreadyout_S[2] = 1'b1;
    Hrdata_S[95:64] = 32'h1234_5678;
    #1;
    check("read Hready", 64'(Hready), 64'd1);
    check("read rdata1", 64'(Hrdata_M[63:32]), 64'h1234_5678);
    check("read rdata0", 64'(Hrdata_M[31:0]),  64'(DEF));
    check("read resp",   64'(Hresp_M), 64'd0);
    tick();   // accepts IDLE, unmapped, master 0
    check_idle_outputs("idle_unmapped");
    check("idle cnt", 64'(err_count), 64'd0);

    // Unmapped NONSEQ from master 0
    Hsel = 4'b0000; Htrans = 2'b10; Hmaster = 1'b0;
    tick();
    exp_cnt = 1;
    Htrans = 2'b00;
    check("err1 Hready", 64'(Hready), 64'd0);
    check("err1 resp",   64'(Hresp_M), 64'b00_01);
    check("err1 rdata0", 64'(Hrdata_M[31:0]), 64'(DEF));
    check("err1 cnt",    64'(err_count), 64'(exp_cnt));
    tick();
    check("err2 Hready", 64'(Hready), 64'd1);
    check("err2 resp",   64'(Hresp_M), 64'b00_01);
    check("err2 cnt",    64'(err_count), 64'(exp_cnt));
    tick();
    check_idle_outputs("after_err");
    Htrans = 2'b01;   // BUSY to unmapped space
    tick();
    check_idle_outputs("busy_unmapped");
    check("busy cnt", 64'(err_count), 64'(exp_cnt));

    // Three back-to-back unmapped transfers from master 1
    Htrans = 2'b10; Hmaster = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_cnt++;
      check("b2b err1 Hready", 64'(Hready), 64'd0);
      check("b2b err1 resp",   64'(Hresp_M), 64'b01_00);
      check("b2b err1 cnt",    64'(err_count), 64'(exp_cnt));
      Htrans = (k == 2) ? 2'b00 : 2'b11;
      tick();
      check("b2b err2 Hready", 64'(Hready), 64'd1);
      check("b2b err2 resp",   64'(Hresp_M), 64'b01_00);
    end
    tick();
    check_idle_outputs("b2b_end");
    check("b2b cnt", 64'(err_count), 64'd4);

    // Drive the counter to saturation, then one more
    Htrans = 2'b10;
    for (int k = 0; k < 251; k++) begin
      tick();
      tick();
    end
    check("sat reach", 64'(err_count), 64'd255);
    tick();
    check("sat err1 Hready", 64'(Hready), 64'd0);
    check("sat hold", 64'(err_count), 64'd255);
    Htrans = 2'b00;
    tick();
    tick();
    check("sat hold2", 64'(err_count), 64'd255);

    // Multi-hot select: lowest index (slave 1) wins
    Hsel = 4'b1010; Htrans = 2'b10; Hmaster = 1'b0;
    Hrdata_S[63:32]  = 32'hAAAA_0001;
    Hrdata_S[127:96] = 32'hBBBB_0003;
    Hresp_S = 8'b01_00_00_00;
    tick();
    Hsel = 4'b0000; Htrans = 2'b00;
    check("mhot rdata0", 64'(Hrdata_M[31:0]),  64'hAAAA_0001);
    check("mhot rdata1", 64'(Hrdata_M[63:32]), 64'(DEF));
    check("mhot resp",   64'(Hresp_M), 64'd0);
    Hreadyout_S[3] = 1'b0;
    #1;
    check("mhot ready", 64'(Hready), 64'd1);
    Hreadyout_S[1] = 1'b0;
    #1;
    check("mhot ready1", 64'(Hready), 64'd0);
    Hreadyout_S = 4'b1111;
    tick();

    // Reset asserted during ERR1
    Hsel = 4'b0000; Htrans = 2'b10; Hmaster = 1'b1;
    tick();
    Htrans = 2'b00;
    check("rst err1 Hready", 64'(Hready), 64'd0);
    check("rst err1 mst",    64'(Hmaster_data), 64'd1);
    #2;
    Hresetn = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    check("async_rst cnt", 64'(err_count), 64'd0);
    check("async_rst mst", 64'(Hmaster_data), 64'd0);
    #5;
    Hresetn = 1'b1;
    Hsel = 4'b0001; Htrans = 2'b10; Hmaster = 1'b0;
    Hrdata_S[31:0] = 32'h0000_5A5A;
    Hresp_S = 8'b00;
    tick();
    Hsel = 4'b0000; Htrans = 2'b00;
    check("post_rst Hready", 64'(Hready), 64'd1);
    check("post_rst rdata0", 64'(Hrdata_M[31:0]), 64'h0000_5A5A);
    check("post_rst resp",   64'(Hresp_M), 64'd0);
    check("post_rst cnt",    64'(err_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
